uart_tx_cfg: RTL
================

# uart_tx_cfg

Parametrised UART transmitter with an integrated transmit FIFO, a valid/ready input handshake and configurable frame format: data width, parity mode and stop-bit count. It is the next-generation replacement for the fixed 8N1 transmitter used by the periodic-send application wrapper. It sits between any byte/word producer in the fabric and the board `tx` pin. Successive frames are sent back-to-back with no idle gap while the FIFO holds data.

## Interface
- `BAUD_CNT`, 434: clocks per bit period; legal range ≥ 2 (434 gives 115200 baud at 50 MHz).
- `DATA_BITS`, 8: data bits per frame; legal range 5–8.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥ 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `din`  in  DATA_BITS  word to transmit.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  FIFO can accept a word; a transfer occurs on an edge where `din_valid` and `din_ready` are both 1.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Reset (`rst_n`=0 at an edge) forces:
  - `tx`=1, `busy`=0, `fifo_cnt`=0, `din_ready`=1;
  - FSM to IDLE, baud counter and bit counter to 0;
  - FIFO pointers cleared; stored words are discarded.
- FIFO: `din_ready` = !full, where full means `fifo_cnt`==FIFO_DEPTH.
  - Push while full is impossible by construction; a simultaneous pop does not free space in the same cycle.
  - Push and pop on the same edge leave `fifo_cnt` unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head word into the shift register and go to START.
  - START: `tx`=0 for BAUD_CNT clocks.
  - DATA: send DATA_BITS bits LSB first, each for BAUD_CNT clocks.
  - PARITY: present only when PARITY≠0; one bit period.
    - Even mode: parity bit = XOR of the data bits.
    - Odd mode: parity bit = inverted XOR of the data bits.
  - STOP: `tx`=1 for STOP_BITS×BAUD_CNT clocks.
  - STOP exit, FIFO non-empty: pop on that exit edge and go directly to START, so there is zero idle clocks between frames.
  - STOP exit, FIFO empty: go to IDLE.
- Baud counter: counts 0..BAUD_CNT-1 and wraps. The bit/state advance happens on the edge where the count equals BAUD_CNT-1.
- `busy` = (state≠IDLE) || (`fifo_cnt`≠0).
- `tx` is driven from a register, so the pin never glitches.

## Timing
- First-word latency from an empty, idle block:
  - word accepted on edge k;
  - word popped (IDLE→START) on edge k+1;
  - `tx` falls after edge k+2 because `tx` is registered.
- Frame length: BAUD_CNT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) clocks, measured from the `tx` falling edge of the start bit.
- Back-to-back frames: the next start bit begins exactly one frame length after the previous start bit.
- Every bit period lasts exactly BAUD_CNT clocks; no bit may be shortened or stretched.
- `fifo_cnt` and `din_ready` update on the edge after a push or pop.
- Reset mid-frame:
  - `tx` is 1 after the reset edge;
  - the partial frame is abandoned;
  - nothing resumes after reset is released until a new push.
- `din` and `din_valid` are ignored while `rst_n`=0.

## Test plan
- Default format (BAUD_CNT=10, 8N1): push 0x55 → `tx` reads 0 then 1,0,1,0,1,0,1,0 then 1, each bit 10 clocks; 100-clock frame; `busy` returns to 0 afterwards.
- Parity modes (BAUD_CNT=10):
  - PARITY=2, push 0x07 → parity bit 1, 110-clock frame.
  - PARITY=1, push 0x00 → parity bit 1.
  - PARITY=1, push 0x03 → parity bit 1.
- Short format (DATA_BITS=5, STOP_BITS=2, PARITY=0, BAUD_CNT=10): push 0x1F → frame of 80 clocks, with 20 clocks high at the end.
- Backpressure (FIFO_DEPTH=8): hold `din_valid`=1 with words 0x00..0x09 from idle.
  - Exactly 9 words are accepted, then `din_ready`=0 and `fifo_cnt`=8.
  - The 10th word is accepted when the first frame ends.
  - All 10 words appear on `tx` in order with no idle gap.
- Reset mid-frame: assert `rst_n`=0 during the data bits of the 2nd of 3 queued words.
  - `tx`=1 and `fifo_cnt`=0 on the next edge.
  - No further frames are sent after release.
  - A new push of 0xA5 transmits correctly.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a transmit FIFO, valid/ready input and a configurable frame
// format (data width, parity, stop bits). Frames go out back-to-back while words are queued.
module uart_tx_cfg #(
    parameter int unsigned BAUD_CNT   = 434,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(BAUD_CNT);
    localparam int unsigned BIT_W  = 3;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic              ODD_PAR   = (PARITY == 1);
    localparam logic              HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q,  state_d;
    logic [BAUD_W-1:0]      baud_q,   baud_d;
    logic [BIT_W-1:0]       bit_q,    bit_d;
    logic [DATA_BITS-1:0]   shift_q,  shift_d;
    logic                   par_q,    par_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   tx_q,     tx_d;
    logic                   busy_q,   busy_d;
    logic                   ready_q,  ready_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic                   baud_tick;
    logic [DATA_BITS-1:0]   head;

    // Next-state, FIFO bookkeeping and registered-output computation
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        push      = din_valid && ready_q;
        head      = mem_q[rd_ptr_q];
        baud_tick = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Popping on the stop exit edge keeps frames gap-free
                        if (cnt_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            shift_d  = head;
            par_d    = (^head) ^ ODD_PAR;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase

        ready_d = (cnt_d != FULL_CNT);
        busy_d  = (state_d != S_IDLE) || (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign din_ready = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_cnt  = cnt_q;

endmodule
